// File: rtl/p_fxp_acc_seq_if.sv
// Operand/result stream bundle for the sequential fixed-point accumulator.
// slave is the accumulator side, master is the operand source and sum sink.
interface p_fxp_acc_seq_if #(
  parameter int PREC = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [PREC-1:0] in;
  logic            out_valid;
  logic            out_ready;
  logic [PREC-1:0] out;
  logic            ovf;
  logic            udf;
  logic            rounded;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, ovf, udf, rounded
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, ovf, udf, rounded
  );
endinterface

// File: rtl/p_fxp_acc_seq.sv
// Time-serial fixed-point accumulator: sums IN operands per packet with
// two's-complement wrap and a sticky overflow flag, one operand per cycle.
package dconf_pkg;
  typedef struct packed {
    logic       sign;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;

  localparam dconf_t DEF_DCONF_FXP = '{sign: 1'b1, prec: 8'd8, frac: 8'd4};
endpackage

module p_fxp_acc_seq #(
  parameter int                IN   = 8,
  parameter dconf_pkg::dconf_t CONF = dconf_pkg::DEF_DCONF_FXP
) (
  input logic            clk,
  input logic            reset_,
  p_fxp_acc_seq_if.slave bus
);
  localparam int PREC = int'(CONF.prec);
  localparam int CW   = $clog2(IN + 1);
  localparam logic [CW-1:0] LAST = CW'(IN - 1);

  typedef enum logic {ACC, HOLD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PREC-1:0] acc;
  logic            ovf_acc;
  logic [PREC-1:0] out_r;
  logic            ovf_out;

  logic [PREC:0]   sum;
  logic            signed_ovf;
  logic            beat_ovf;

  // Extra top bit of sum is the unsigned carry; signed overflow looks at sign bits only.
  assign sum        = {1'b0, acc} + {1'b0, bus.in};
  assign signed_ovf = (acc[PREC-1] == bus.in[PREC-1]) && (sum[PREC-1] != acc[PREC-1]);
  assign beat_ovf   = CONF.sign ? signed_ovf : sum[PREC];

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state   <= ACC;
      cnt     <= '0;
      acc     <= '0;
      ovf_acc <= 1'b0;
      out_r   <= '0;
      ovf_out <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (bus.in_valid) begin
            if (cnt == LAST) begin
              out_r   <= sum[PREC-1:0];
              ovf_out <= ovf_acc | beat_ovf;
              cnt     <= '0;
              state   <= HOLD;
            end else begin
              acc     <= sum[PREC-1:0];
              ovf_acc <= ovf_acc | beat_ovf;
              cnt     <= cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          // Release clears the running sum; no operand is taken this cycle.
          if (bus.out_ready) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
            state   <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == HOLD);
  assign bus.out       = out_r;
  assign bus.ovf       = ovf_out;
  assign bus.udf       = 1'b0;
  assign bus.rounded   = 1'b0;
endmodule

// File: doc/p_fxp_acc_seq.md
# p_fxp_acc_seq

Sequential fixed-point accumulator: the time-serial counterpart of the parallel adder-tree accumulator. It consumes one fixed-point operand per cycle over a valid/ready stream and sums exactly `IN` operands per packet. It then presents the sum on a valid/ready output with the same status flags as the combinational tree. It sits between a serial operand source (e.g. a weight×input product stream) and the perceptron activation stage, where area matters more than latency.

## Interface
- `IN`, 8, operands per packet; legal range ≥ 1.
- `CONF`, `DEF_DCONF_FXP`, fixed-point format (dconf_t); `CONF.sign` selects signed/unsigned.
- `PREC`, `CONF.prec`, operand/result width (derived; do not override).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset_`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  block can accept an operand.
- `in`  in  PREC  operand, same format as `CONF`.
- `out_valid`  out  1  packet sum valid.
- `out_ready`  in  1  downstream accepts sum.
- `out`  out  PREC  packet sum.
- `ovf`  out  1  sticky overflow for the packet; valid with `out_valid`.
- `udf`  out  1  tied to `Disable`.
- `rounded`  out  1  tied to `Disable`.

## Operation
- **States.**
  - ACC: collect operands; `in_ready`=1, `out_valid`=0.
  - HOLD: present the result; `in_ready`=0, `out_valid`=1.
- **Beat counter.** Counter `cnt`, width `$clog2(IN+1)`, counts accepted beats (`in_valid && in_ready`).
- **Accepted beat with `cnt < IN-1`.** `acc <= acc + in`, `ovf_r <= ovf_r | beat_ovf`, `cnt <= cnt+1`.
- **Accepted beat with `cnt == IN-1`.** Same update into the `out` register, then `cnt <= 0` and go to HOLD.
- **HOLD exit.** On `out_valid && out_ready`, clear `acc` and `ovf_r` and go to ACC. No operand is accepted in the same cycle as output release.
- **Arithmetic.** The sum is PREC bits with two's-complement wrap. No saturation, no scaling; the binary point is unchanged.
- **`beat_ovf`.**
  - Signed: both operands have the same sign and the result sign differs.
  - Unsigned: carry out of bit PREC-1.
- **Sticky flag.** `ovf` stays set once set, even if later beats wrap back into range.
- **IN=1.** `out` = `in` and `ovf` = 0, one cycle after acceptance.
- **Idle input.** `in_valid`=0 during ACC leaves all state unchanged. Gaps between beats are legal.
- **Stability in HOLD.** `out` and `ovf` stay stable until the handshake completes. `in` is ignored while `in_ready`=0.

## Timing
- **Reset values (while `reset_`=0 and after release).**
  - state = ACC, `cnt` = 0, `acc` = 0.
  - `out` = 0, `ovf` = 0, `out_valid` = 0, `in_ready` = 1.
- **Latency.** `out_valid` rises on the edge that accepts the IN-th operand, so it is visible the cycle after the last beat.
- **Throughput.** Minimum IN+1 cycles per packet with `in_valid`=1 and `out_ready`=1 continuously: IN accept cycles plus one HOLD cycle.
- **Output register.** `in_ready` and `out_valid` are pure decodes of the registered state. `out` and `ovf` are registered outputs.
- **No combinational paths.** There is no path from `out_ready` to `in_ready`, and none from `in_valid` to `out_valid`.
- **Reset mid-packet.** Reset discards the partial sum and count. The first beat accepted after release is beat 0 of a new packet.
- **Reset during HOLD.** Reset drops `out_valid` asynchronously; the pending sum is lost.

## Test plan
- **Basic sum.** PREC=8 signed, IN=4. Stream 1,2,3,4 back-to-back -> `out_valid` the cycle after beat 4, `out`=10, `ovf`=0.
- **Sticky overflow.** Same config, stream 100,50,-20,1 -> `out`=-125 (8'h83), `ovf`=1 (wrap at 100+50).
- **Output backpressure.** Hold `out_ready`=0 for 5 cycles after `out_valid` -> `out`/`ovf` stable, `in_ready`=0, and operands driven meanwhile are not summed. Then raise `out_ready` -> the next packet 5,5,5,5 gives 20.
- **Input gaps.** Stream 1,2,3,4 with random `in_valid` gaps -> `out`=10. Sustained ready/valid gives one packet per 5 cycles.
- **Reset mid-packet.** Accept 7,7, pulse `reset_` low, then stream 1,1,1,1 -> `out`=4, `ovf`=0. Outputs read reset values during reset.
- **Unsigned and IN=1 edges.**
  - CONF unsigned, PREC=8, IN=2: 200+100 -> `out`=44, `ovf`=1.
  - IN=1: input 8'h5A -> `out`=8'h5A one cycle later, `ovf`=0.
